// File: rtl/pattern_gen_pkg.sv
// Shared types and helpers for the pattern generator: mode encoding,
// maximal-length Galois LFSR tap masks, and binary-to-Gray conversion.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SHIFT = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_GRAY  = 2'd3
  } mode_e;

  // Right-shifting Galois masks: tap n of the polynomial sits in bit n-1.
  function automatic logic [63:0] lfsr_taps(input int width);
    logic [63:0] m;
    m = '0;
    case (width)
      4:  m = 64'h0000_0000_0000_000C;
      5:  m = 64'h0000_0000_0000_0014;
      6:  m = 64'h0000_0000_0000_0030;
      7:  m = 64'h0000_0000_0000_0060;
      8:  m = 64'h0000_0000_0000_00B8;
      9:  m = 64'h0000_0000_0000_0110;
      10: m = 64'h0000_0000_0000_0240;
      11: m = 64'h0000_0000_0000_0500;
      12: m = 64'h0000_0000_0000_0829;
      13: m = 64'h0000_0000_0000_100D;
      14: m = 64'h0000_0000_0000_2015;
      15: m = 64'h0000_0000_0000_6000;
      16: m = 64'h0000_0000_0000_D008;
      17: m = 64'h0000_0000_0001_2000;
      18: m = 64'h0000_0000_0002_0400;
      19: m = 64'h0000_0000_0004_0023;
      20: m = 64'h0000_0000_0009_0000;
      21: m = 64'h0000_0000_0014_0000;
      22: m = 64'h0000_0000_0030_0000;
      23: m = 64'h0000_0000_0042_0000;
      24: m = 64'h0000_0000_00E1_0000;
      25: m = 64'h0000_0000_0120_0000;
      26: m = 64'h0000_0000_0200_0023;
      27: m = 64'h0000_0000_0400_0013;
      28: m = 64'h0000_0000_0900_0000;
      29: m = 64'h0000_0000_1400_0000;
      30: m = 64'h0000_0000_2000_0029;
      31: m = 64'h0000_0000_4800_0000;
      32: m = 64'h0000_0000_8020_0003;
      33: m = 64'h0000_0001_0008_0000;
      34: m = 64'h0000_0002_0400_0003;
      35: m = 64'h0000_0005_0000_0000;
      36: m = 64'h0000_0008_0100_0000;
      37: m = 64'h0000_0010_0000_001F;
      38: m = 64'h0000_0020_0000_0031;
      39: m = 64'h0000_0044_0000_0000;
      40: m = 64'h0000_00A0_0014_0000;
      41: m = 64'h0000_0120_0000_0000;
      42: m = 64'h0000_0300_000C_0000;
      43: m = 64'h0000_0630_0000_0000;
      44: m = 64'h0000_0C00_0003_0000;
      45: m = 64'h0000_1B00_0000_0000;
      46: m = 64'h0000_3000_0300_0000;
      47: m = 64'h0000_4200_0000_0000;
      48: m = 64'h0000_C000_0018_0000;
      49: m = 64'h0001_0080_0000_0000;
      50: m = 64'h0003_0000_00C0_0000;
      51: m = 64'h0006_000C_0000_0000;
      52: m = 64'h0009_0000_0000_0000;
      53: m = 64'h0018_0030_0000_0000;
      54: m = 64'h0030_0000_0003_0000;
      55: m = 64'h0040_0000_4000_0000;
      56: m = 64'h00C0_0006_0000_0000;
      57: m = 64'h0102_0000_0000_0000;
      58: m = 64'h0200_0040_0000_0000;
      59: m = 64'h0600_0030_0000_0000;
      60: m = 64'h0C00_0000_0000_0000;
      61: m = 64'h1800_3000_0000_0000;
      62: m = 64'h3000_0000_0000_0030;
      63: m = 64'h6000_0000_0000_0000;
      64: m = 64'hD800_0000_0000_0000;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] to_gray(input logic [63:0] v);
    return v ^ (v >> 1);
  endfunction

endpackage

// File: rtl/pattern_gen_ch.sv
// One pattern channel: state register stepped by the selected mode, with a
// registered one-cycle wrap flag and a mode-dependent output encoding.
module pattern_gen_ch
  import pattern_gen_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int          SHIFT_STEP = 2,
  parameter logic [63:0] LFSR_SEED  = 64'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] out_o,
  output logic             wrap_o
);

  localparam logic [63:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED      = LFSR_SEED[WIDTH-1:0];

  mode_e            mode;
  logic [WIDTH-1:0] state_p0;
  logic             wrap_p0;
  logic [WIDTH-1:0] state_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] shift_nxt;
  logic [63:0]      gray_full;

  assign mode      = mode_e'(mode_i);
  assign lfsr_nxt  = (state_p0 >> 1) ^ (state_p0[0] ? TAPS : '0);
  assign shift_nxt = {state_p0[WIDTH-1-SHIFT_STEP:0], {SHIFT_STEP{1'b1}}};

  always_comb begin
    state_nxt = state_p0;
    wrap_nxt  = 1'b0;
    if (load_i) begin
      state_nxt = load_val_i;
    end else if (en_i) begin
      case (mode)
        MODE_COUNT, MODE_GRAY: begin
          state_nxt = state_p0 + WIDTH'(1);
          wrap_nxt  = &state_p0;
        end
        MODE_SHIFT: begin
          if (&state_p0) begin
            state_nxt = '0;
            wrap_nxt  = 1'b1;
          end else begin
            state_nxt = shift_nxt;
          end
        end
        MODE_LFSR: begin
          // Zero is the LFSR lock-up state, so it re-seeds without flagging a wrap.
          if (state_p0 == '0) begin
            state_nxt = SEED;
          end else begin
            state_nxt = lfsr_nxt;
            wrap_nxt  = (lfsr_nxt == SEED);
          end
        end
        default: state_nxt = state_p0;
      endcase
    end
  end

  // stage p0: channel state and wrap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= '0;
      wrap_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      wrap_p0  <= wrap_nxt;
    end
  end

  assign gray_full = to_gray(64'(state_p0));
  assign out_o     = (mode == MODE_GRAY) ? gray_full[WIDTH-1:0] : state_p0;
  assign wrap_o    = wrap_p0;

endmodule

// File: rtl/pattern_gen.sv
// Multi-channel activity generator: NUM_CH independent pattern channels plus
// a saturating count of enabled cycles.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          WIDTH      = 8,
  parameter int          SHIFT_STEP = 2,
  parameter logic [63:0] LFSR_SEED  = 64'd1,
  parameter int          CYC_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic [2*NUM_CH-1:0]     mode_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic [WIDTH*NUM_CH-1:0] load_val_i,
  output logic [WIDTH*NUM_CH-1:0] out_o,
  output logic [NUM_CH-1:0]       wrap_o,
  output logic [CYC_W-1:0]        cyc_o
);

  logic [CYC_W-1:0] cyc_p0;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pattern_gen_ch #(
      .WIDTH      (WIDTH),
      .SHIFT_STEP (SHIFT_STEP),
      .LFSR_SEED  (LFSR_SEED)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en_i),
      .mode_i     (mode_i[2*c +: 2]),
      .load_i     (load_i[c]),
      .load_val_i (load_val_i[WIDTH*c +: WIDTH]),
      .out_o      (out_o[WIDTH*c +: WIDTH]),
      .wrap_o     (wrap_o[c])
    );
  end

  // stage p0: enabled-cycle counter, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_p0 <= '0;
    end else if (en_i && !(&cyc_p0)) begin
      cyc_p0 <= cyc_p0 + CYC_W'(1);
    end
  end

  assign cyc_o = cyc_p0;

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: arithmetic reference model compared every cycle,
// directed sequences with literal expectations, and randomized traffic.
module tb_pattern_gen;

  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en_i = 1'b0;
  logic [7:0]  mode_i = '0;
  logic [3:0]  load_i = '0;
  logic [31:0] load_val_i = '0;
  logic [31:0] out_o, out_s;
  logic [3:0]  wrap_o, wrap_s;
  logic [15:0] cyc_o;
  logic [3:0]  cyc_s;

  pattern_gen #(.NUM_CH(4), .WIDTH(8), .SHIFT_STEP(2), .LFSR_SEED(64'd1), .CYC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .mode_i(mode_i), .load_i(load_i),
    .load_val_i(load_val_i), .out_o(out_o), .wrap_o(wrap_o), .cyc_o(cyc_o));

  pattern_gen #(.NUM_CH(4), .WIDTH(8), .SHIFT_STEP(2), .LFSR_SEED(64'd1), .CYC_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .mode_i(mode_i), .load_i(load_i),
    .load_val_i(load_val_i), .out_o(out_s), .wrap_o(wrap_s), .cyc_o(cyc_s));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state per channel, next value from plain arithmetic.
  logic [7:0]        m_state [NUM_CH];
  logic [NUM_CH-1:0] m_wrap;
  int                m_cyc;

  function automatic logic [8:0] model_step(input int mode, input int s);
    int n;
    bit w;
    n = 0;
    w = 1'b0;
    case (mode)
      1: if (s == 255) begin n = 0; w = 1'b1; end else n = (s * 4 + 3) % 256;
      2: if (s == 0) n = 1; else begin n = (s / 2) ^ ((s % 2 == 1) ? 184 : 0); w = (n == 1); end
      default: begin n = (s + 1) % 256; w = (s == 255); end
    endcase
    return {w, n[7:0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wrap <= '0;
      m_cyc  <= 0;
      for (int c = 0; c < NUM_CH; c++) m_state[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (load_i[c]) begin
          m_state[c] <= load_val_i[8*c +: 8];
          m_wrap[c]  <= 1'b0;
        end else if (en_i) begin
          {m_wrap[c], m_state[c]} <= model_step(int'(mode_i[2*c +: 2]), int'(m_state[c]));
        end else begin
          m_wrap[c] <= 1'b0;
        end
      end
      if (en_i) m_cyc <= m_cyc + 1;
    end
  end

  function automatic logic [31:0] exp_out();
    logic [31:0] e;
    int s;
    for (int c = 0; c < NUM_CH; c++) begin
      s = int'(m_state[c]);
      if (mode_i[2*c +: 2] == 2'd3) s = s ^ (s / 2);
      e[8*c +: 8] = s[7:0];
    end
    return e;
  endfunction

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        check("out", out_o, exp_out());
        check("wrap", wrap_o, m_wrap);
        check("cyc", cyc_o, sat(m_cyc, 65535));
        check("out_s", out_s, exp_out());
        check("wrap_s", wrap_s, m_wrap);
        check("cyc_s", cyc_s, sat(m_cyc, 15));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic adv();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(3))
      0: return 8'hFF;
      1: return 8'hFE;
      2: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  logic [31:0] seq_out  [6] = '{32'h01010301, 32'h03B80F02, 32'h025C3F03,
                                32'h062EFF04, 32'h07170005, 32'h05B30306};
  logic [3:0]  seq_wrap [6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
  int period, zeros;

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) adv();
    check("rst_out", out_o, 32'h0);
    check("rst_wrap", wrap_o, 4'h0);
    check("rst_cyc", cyc_o, 16'h0);
    check("model_shift_wrap", model_step(1, 255), {1'b1, 8'h00});
    check("model_lfsr_b8", model_step(2, 1), {1'b0, 8'hB8});

    // ch0 COUNT, ch1 SHIFT, ch2 LFSR, ch3 GRAY, all from reset
    rst_n  = 1'b1;
    mode_i = 8'hE4;
    en_i   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      adv();
      check("seq_out", out_o, seq_out[k]);
      check("seq_wrap", wrap_o, seq_wrap[k]);
    end

    load_i = 4'b0001; load_val_i = 32'h0000_00FE;
    adv(); check("ld_fe", out_o[7:0], 8'hFE);
    load_i = 4'b0000;
    adv(); check("cnt_ff", out_o[7:0], 8'hFF); check("cnt_ff_wrap", wrap_o[0], 1'b0);
    adv(); check("cnt_00", out_o[7:0], 8'h00); check("cnt_00_wrap", wrap_o[0], 1'b1);
    adv(); check("cnt_01", out_o[7:0], 8'h01); check("cnt_01_wrap", wrap_o[0], 1'b0);

    load_i = 4'b1000; load_val_i = 32'hFF00_0000;
    adv(); check("gray_ff", out_o[31:24], 8'h80);
    load_i = 4'b0000;
    adv(); check("gray_00", out_o[31:24], 8'h00); check("gray_wrap", wrap_o[3], 1'b1);
    adv(); check("gray_01", out_o[31:24], 8'h01); check("gray_wrap_clr", wrap_o[3], 1'b0);

    en_i = 1'b0; load_i = 4'b0001; load_val_i = 32'h0000_005A;
    adv(); check("ld_no_en", out_o[7:0], 8'h5A); check("cyc_no_en", cyc_o, 16'd13);
    en_i = 1'b1;
    adv(); check("ld_over_en", out_o[7:0], 8'h5A);
    load_val_i = 32'h0000_0004;
    adv(); check("ld_04", out_o[7:0], 8'h04);
    load_i = 4'b0000; mode_i = 8'hE5;
    adv(); check("mode_sw", out_o[7:0], 8'h13);
    mode_i = 8'hE4;

    load_i = 4'b0100; load_val_i = 32'h0001_0000;
    adv(); check("lfsr_seed", out_o[23:16], 8'h01);
    load_i = 4'b0000;
    period = 0;
    zeros  = 0;
    for (int i = 1; i <= 300; i++) begin
      adv();
      if (out_o[23:16] == 8'h00) zeros++;
      if (wrap_o[2] && period == 0) period = i;
      if (period != 0) break;
    end
    check("lfsr_period", period, 255);
    check("lfsr_no_zero", zeros, 0);
    check("lfsr_back", out_o[23:16], 8'h01);

    repeat (1500) begin
      en_i       = ($urandom_range(3) != 0);
      load_i     = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        load_i[c] = ($urandom_range(9) == 0);
        load_val_i[8*c +: 8] = pick_byte();
      end
      if ($urandom_range(9) == 0) mode_i = 8'($urandom);
      adv();
    end

    // reset, then run to cyc_o=37 with a wrap on ch0 and reset mid-cycle
    en_i = 1'b0; load_i = '0; mode_i = 8'h00;
    adv();
    rst_n = 1'b0;
    adv();
    rst_n = 1'b1;
    en_i  = 1'b1;
    adv(); check("first_after_rst", out_o, 32'h01010101);
    for (int i = 2; i <= 37; i++) begin
      load_i     = (i == 36) ? 4'b0001 : 4'b0000;
      load_val_i = 32'h0000_00FF;
      adv();
      if (i == 14) check("cyc_s_14", cyc_s, 4'd14);
      if (i == 20) check("cyc_s_sat", cyc_s, 4'd15);
    end
    check("cyc_37", cyc_o, 16'd37);
    check("wrap_pend", wrap_o[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_out", out_o, 32'h0);
    check("async_wrap", wrap_o, 4'h0);
    check("async_cyc", cyc_o, 16'h0);
    check("async_cyc_s", cyc_s, 4'h0);
    adv();
    rst_n = 1'b1;
    load_i = '0;

    repeat (300) begin
      en_i   = ($urandom_range(1) != 0);
      load_i = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0000;
      load_val_i = $urandom;
      if ($urandom_range(7) == 0) mode_i = 8'($urandom);
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
